// File: rtl/izhikevich_scheduler.sv
// izhikevich_scheduler
//   Time-multiplexes one shared izhikevich_core across NEURONS logical neurons.
//   Per-neuron membrane voltage (vmem) and recovery (wmem) live in local
//   register arrays. On start, each neuron in turn is loaded into the core,
//   advanced once, and written back. The step then finishes with a one-cycle
//   DONE state.
//
// Optional feature: define IZH_SCHED_SPIKE_COUNT_EN to add the spike_total
//   output, which holds the popcount of the last completed step's spikes.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   start             request one time step (accepted in IDLE only)
//   i_bus             per-neuron input currents, neuron k at [k*N +: N]
//   v_init, w_init    reset values loaded into every neuron
//   busy, done        step in progress / one-cycle completion pulse
//   spikes            spike flags of the last completed step
//   step_count        completed steps, wraps at 16 bits
//   rd_addr           readback index; rd_voltage/rd_w registered readback
//   core_*            drive and observe the shared izhikevich_core
module izhikevich_scheduler #(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int NEURONS = 8,
    localparam int AW     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NEURONS*N-1:0]   i_bus,
    input  logic [N-1:0]           v_init,
    input  logic [N-1:0]           w_init,
    output logic                   busy,
    output logic                   done,
    output logic [NEURONS-1:0]     spikes,
    output logic [15:0]            step_count,
`ifdef IZH_SCHED_SPIKE_COUNT_EN
    output logic [$clog2(NEURONS+1)-1:0] spike_total,
`endif
    input  logic [AW-1:0]          rd_addr,
    output logic [N-1:0]           rd_voltage,
    output logic [N-1:0]           rd_w,
    output logic                   core_load,
    output logic [N-1:0]           core_v_init,
    output logic [N-1:0]           core_w_init,
    output logic [N-1:0]           core_i,
    output logic                   core_apply,
    input  logic [N-1:0]           core_voltage,
    input  logic [N-1:0]           core_w,
    input  logic                   core_spiking
);

    // Q is the core's fixed-point position; no arithmetic happens here, but a
    // nonsensical value is rejected at elaboration.
    if (Q >= N) begin : g_q_range
        $error("izhikevich_scheduler: Q must be smaller than N");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] K_LAST = AW'(NEURONS - 1);

    state_t               state_q, state_d;
    logic [AW-1:0]        k_q, k_d;
    logic [N-1:0]         vmem_q [NEURONS];
    logic [N-1:0]         wmem_q [NEURONS];
    logic [N-1:0]         cur_q  [NEURONS];
    logic [NEURONS-1:0]   spike_acc_q, spike_acc_d;
    logic [NEURONS-1:0]   spikes_q;
    logic [15:0]          step_count_q;
    logic [N-1:0]         rd_voltage_q, rd_w_q;
    logic                 last_neuron;

`ifdef IZH_SCHED_SPIKE_COUNT_EN
    localparam int SW = $clog2(NEURONS + 1);
    logic [SW-1:0] spike_total_q;

    function automatic logic [SW-1:0] popcount(input logic [NEURONS-1:0] v);
        logic [SW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NEURONS; i++) begin
            cnt = cnt + SW'(v[i]);
        end
        return cnt;
    endfunction

    assign spike_total = spike_total_q;
`endif

    assign last_neuron = (k_q == K_LAST);

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        spike_acc_d = spike_acc_q;
        spike_acc_d[k_q] = core_spiking;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                end
            end
            S_LOAD:  state_d = S_APPLY;
            S_APPLY: state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (last_neuron) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    k_d     = k_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, neuron memories and readback
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            spike_acc_q  <= '0;
            spikes_q     <= '0;
            step_count_q <= '0;
            rd_voltage_q <= '0;
            rd_w_q       <= '0;
            for (int i = 0; i < NEURONS; i++) begin
                vmem_q[i] <= v_init;
                wmem_q[i] <= w_init;
            end
`ifdef IZH_SCHED_SPIKE_COUNT_EN
            spike_total_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            // Readback samples before this edge's CAPTURE write lands, so a
            // same-index collision returns the pre-write value.
            if (32'(rd_addr) < NEURONS) begin
                rd_voltage_q <= vmem_q[rd_addr];
                rd_w_q       <= wmem_q[rd_addr];
            end else begin
                rd_voltage_q <= '0;
                rd_w_q       <= '0;
            end
            if (state_q == S_CAPTURE) begin
                vmem_q[k_q] <= core_voltage;
                wmem_q[k_q] <= core_w;
                spike_acc_q <= spike_acc_d;
                // Publish on entry to DONE so results are visible with done.
                if (last_neuron) begin
                    spikes_q     <= spike_acc_d;
                    step_count_q <= step_count_q + 16'd1;
`ifdef IZH_SCHED_SPIKE_COUNT_EN
                    spike_total_q <= popcount(spike_acc_d);
`endif
                end
            end
        end
    end

    // Input currents are snapshotted at start so i_bus may change mid-step.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            for (int i = 0; i < NEURONS; i++) begin
                cur_q[i] <= i_bus[i*N +: N];
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign core_load   = (state_q == S_LOAD);
    assign core_apply  = (state_q == S_APPLY);
    assign core_v_init = vmem_q[k_q];
    assign core_w_init = wmem_q[k_q];
    assign core_i      = (state_q == S_IDLE) ? '0 : cur_q[k_q];
    assign spikes      = spikes_q;
    assign step_count  = step_count_q;
    assign rd_voltage  = rd_voltage_q;
    assign rd_w        = rd_w_q;

endmodule

// File: tb/tb_izhikevich_scheduler.sv
// Testbench for izhikevich_scheduler with a behavioural stand-in core.
module tb_izhikevich_scheduler;
    localparam int NU = 5;
    localparam int W  = 32;
    localparam int AW = 3;
    localparam logic [W-1:0] VTH = 32'h001E0000;  // 30.0
    localparam logic [W-1:0] CR  = 32'hFFBF0000;  // -65.0
    localparam logic [W-1:0] DR  = 32'h00080000;  // 8.0
    localparam logic [W-1:0] ONE = 32'h00010000;  // 1.0

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, busy, done;
    logic [NU*W-1:0]   i_bus;
    logic [W-1:0]      v_init, w_init, rd_voltage, rd_w;
    logic [NU-1:0]     spikes;
    logic [15:0]       step_count;
    logic [AW-1:0]     rd_addr;
    logic              core_load, core_apply, core_spiking;
    logic [W-1:0]      core_v_init, core_w_init, core_i, core_voltage, core_w;
`ifdef IZH_SCHED_SPIKE_COUNT_EN
    logic [$clog2(NU+1)-1:0] spike_total;
`endif

    izhikevich_scheduler #(.N(W), .Q(16), .NEURONS(NU)) dut (
        .clk(clk), .rst(rst), .start(start), .i_bus(i_bus),
        .v_init(v_init), .w_init(w_init), .busy(busy), .done(done),
        .spikes(spikes), .step_count(step_count),
`ifdef IZH_SCHED_SPIKE_COUNT_EN
        .spike_total(spike_total),
`endif
        .rd_addr(rd_addr), .rd_voltage(rd_voltage), .rd_w(rd_w),
        .core_load(core_load), .core_v_init(core_v_init), .core_w_init(core_w_init),
        .core_i(core_i), .core_apply(core_apply), .core_voltage(core_voltage),
        .core_w(core_w), .core_spiking(core_spiking)
    );

    // Stand-in core: v += i; spike if v >= 30.0, then v = c, w += d; else w += 1.0
    function automatic logic [2*W:0] core_step(input logic [W-1:0] v, input logic [W-1:0] w,
                                               input logic [W-1:0] i);
        logic signed [W-1:0] s;
        s = $signed(v) + $signed(i);
        if (s >= $signed(VTH)) return {1'b1, CR, w + DR};
        return {1'b0, s, w + ONE};
    endfunction

    logic [W-1:0] cv = '0, cw = '0;
    logic         csp = 1'b0;
    always @(posedge clk) begin
        logic [2*W:0] r;
        if (core_load) begin
            cv  <= core_v_init;
            cw  <= core_w_init;
            csp <= 1'b0;
        end else if (core_apply) begin
            r = core_step(cv, cw, core_i);
            csp <= r[2*W];
            cv  <= r[2*W-1:W];
            cw  <= r[W-1:0];
        end
    end
    assign core_voltage = cv;
    assign core_w       = cw;
    assign core_spiking = csp;

    // Scoreboard and reference state
    typedef struct {
        logic [NU-1:0] spk;
        logic [15:0]   sc;
        int            pc;
    } exp_t;
    exp_t         sb[$];
    logic [W-1:0] mv[NU], mw[NU], ib[NU];
    logic [15:0]  sc_m;
    int checks = 0, failures = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_ibus();
        for (int k = 0; k < NU; k++) i_bus[k*W +: W] = ib[k];
    endtask

    task automatic do_reset(input logic [W-1:0] vi, input logic [W-1:0] wi);
        v_init = vi;
        w_init = wi;
        rst    = 1'b0;
        tick();
        tick();
        for (int k = 0; k < NU; k++) begin
            mv[k] = vi;
            mw[k] = wi;
        end
        sc_m = '0;
        sb.delete();
        rst = 1'b1;
    endtask

    task automatic start_step();
        exp_t e;
        logic [2*W:0] r;
        e.spk = '0;
        e.pc  = 0;
        for (int k = 0; k < NU; k++) begin
            r = core_step(mv[k], mw[k], ib[k]);
            e.spk[k] = r[2*W];
            e.pc += int'(r[2*W]);
            mv[k] = r[2*W-1:W];
            mw[k] = r[W-1:0];
        end
        sc_m = sc_m + 16'd1;
        e.sc = sc_m;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 100 && !done; c++) tick();
        chk("done_within_budget", 64'(done), 64'(1));
        tick();
    endtask

    task automatic readback_all();
        for (int a = 0; a < 8; a++) begin
            rd_addr = AW'(a);
            tick();
            chk("rd_voltage", 64'(rd_voltage), 64'((a < NU) ? mv[a] : '0));
            chk("rd_w", 64'(rd_w), 64'((a < NU) ? mw[a] : '0));
        end
    endtask

    // Pops an expectation for every done pulse and checks published results
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            chk("done_has_expectation", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("spikes", 64'(spikes), 64'(e.spk));
                chk("step_count", 64'(step_count), 64'(e.sc));
`ifdef IZH_SCHED_SPIKE_COUNT_EN
                chk("spike_total", 64'(spike_total), 64'(e.pc));
`endif
            end
        end
    end

    initial begin
        logic [W-1:0] oldv0;
        int d0;
        start   = 1'b0;
        rd_addr = '0;
        for (int k = 0; k < NU; k++) ib[k] = ONE * (k + 2);
        pack_ibus();

        // Reset state
        do_reset(32'hFFBF0000, 32'hFFF30000);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_core_load", 64'(core_load), 64'(0));
        chk("reset_core_apply", 64'(core_apply), 64'(0));
        chk("reset_spikes", 64'(spikes), 64'(0));
        chk("reset_step_count", 64'(step_count), 64'(0));
        readback_all();

        // Latency and per-cycle control; neuron 1 gets 100.0 and spikes
        ib[1] = 32'h00640000;
        pack_ibus();
        rd_addr = '0;
        oldv0 = mv[0];
        start_step();
        for (int c = 1; c <= 3*NU + 2; c++) begin
            chk("core_load", 64'(core_load), 64'((c <= 3*NU) && (c % 3 == 1)));
            chk("core_apply", 64'(core_apply), 64'((c <= 3*NU) && (c % 3 == 2)));
            chk("busy", 64'(busy), 64'(c <= 3*NU + 1));
            chk("done", 64'(done), 64'(c == 3*NU + 1));
            if ((c <= 3*NU) && (c % 3 == 2)) chk("core_i", 64'(core_i), 64'(ib[(c-2)/3]));
            if (c == 3*NU + 2) chk("core_i_idle", 64'(core_i), 64'(0));
            if (c == 4) chk("rd_prewrite", 64'(rd_voltage), 64'(oldv0));
            if (c == 5) chk("rd_postwrite", 64'(rd_voltage), 64'(mv[0]));
            if (c < 3*NU + 2) tick();
        end
        chk("step_count_after_step", 64'(step_count), 64'(sc_m));
        readback_all();

        // Spike scenario: every neuron starts above threshold
        for (int k = 0; k < NU; k++) ib[k] = '0;
        pack_ibus();
        do_reset(32'h00230000, 32'h0);
        start_step();
        wait_done();
        chk("spikes_all_ones", 64'(spikes), 64'({NU{1'b1}}));
        rd_addr = 3'd2;
        tick();
        chk("spike_v_reset", 64'(rd_voltage), 64'(32'hFFBF0000));
        chk("spike_w_bump", 64'(rd_w), 64'(32'h00080000));
        readback_all();
        start_step();
        wait_done();
        chk("spikes_step2", 64'(spikes), 64'(0));

        // Current routing; i_bus changes mid-step are ignored
        for (int k = 0; k < NU; k++) ib[k] = W'(k + 1);
        pack_ibus();
        do_reset(32'h0, 32'h0);
        start_step();
        tick();
        tick();
        i_bus = {NU{32'h0BAD0000}};
        wait_done();
        for (int k = 0; k < NU; k++) begin
            rd_addr = AW'(k);
            tick();
            chk("route_vmem", 64'(rd_voltage), 64'(k + 1));
        end
        pack_ibus();

        // start while busy is ignored
        d0 = done_cnt;
        start_step();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (3*NU + 6) tick();
        chk("busy_start_one_done", 64'(done_cnt - d0), 64'(1));
        chk("busy_start_no_pending", 64'(sb.size()), 64'(0));

        // Reset in cycle 6 aborts the step
        for (int k = 0; k < NU; k++) ib[k] = ONE * (k + 3);
        pack_ibus();
        start_step();
        repeat (5) tick();
        d0 = done_cnt;
        do_reset(32'hFFBF0000, 32'hFFF30000);
        chk("abort_busy", 64'(busy), 64'(0));
        repeat (3*NU + 6) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        chk("abort_step_count", 64'(step_count), 64'(0));
        readback_all();
        start_step();
        wait_done();
        chk("after_abort_step_count", 64'(step_count), 64'(1));
        readback_all();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
